// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_pkg
//  Purpose  : Shared types and encodings for the multicycle control unit:
//             FSM states, instruction classes, funct commands, ALU codes,
//             datapath select encodings and condition codes.
//  Revision : 1.0  initial release
// ============================================================================
package multicycle_control_unit_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   // Instruction classes (op field)
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_B   = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   // Data-processing commands (funct[4:1])
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // ALU operation codes
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Datapath select encodings
   localparam logic [1:0] SRC_A_REG  = 2'b00;
   localparam logic [1:0] SRC_A_PC   = 2'b01;
   localparam logic [1:0] SRC_B_REG  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;
   localparam logic [1:0] RES_ALU    = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_if
//  Purpose  : Instruction fields in, datapath controls out. master is the
//             control unit, slave is the datapath side.
//             CTRL_MEM_WAIT_EN adds the mem_ready handshake input.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_unit_if #(
   parameter int ALU_CTRL_W = 2
);
   logic [3:0]            cond;
   logic [1:0]            op;
   logic [5:0]            funct;
   logic [3:0]            rd;
   logic [3:0]            alu_flags;
`ifdef CTRL_MEM_WAIT_EN
   logic                  mem_ready;
`endif
   logic                  ir_we;
   logic                  pc_we;
   logic                  mem_we;
   logic                  reg_we;
   logic                  adr_src;
   logic [1:0]            alu_src_a;
   logic [1:0]            alu_src_b;
   logic [1:0]            result_src;
   logic [1:0]            imm_src;
   logic [1:0]            reg_src;
   logic [ALU_CTRL_W-1:0] alu_ctrl;
   logic [3:0]            flags;
   logic [3:0]            state;

   modport master (
`ifdef CTRL_MEM_WAIT_EN
      input  mem_ready,
`endif
      input  cond, op, funct, rd, alu_flags,
      output ir_we, pc_we, mem_we, reg_we, adr_src,
      output alu_src_a, alu_src_b, result_src, imm_src, reg_src,
      output alu_ctrl, flags, state
   );

   modport slave (
`ifdef CTRL_MEM_WAIT_EN
      output mem_ready,
`endif
      output cond, op, funct, rd, alu_flags,
      input  ir_we, pc_we, mem_we, reg_we, adr_src,
      input  alu_src_a, alu_src_b, result_src, imm_src, reg_src,
      input  alu_ctrl, flags, state
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_cond_check.sv
`default_nettype none
// ============================================================================
//  Module   : cond_check
//  Purpose  : ARM condition evaluation on NZCV flags {N,Z,C,V}.
//  Revision : 1.0  initial release
// ============================================================================
module cond_check
   import multicycle_control_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);
   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   // Condition table lookup; NV never executes
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Multicycle ARM-subset control FSM with NZCV flag register and
//             condition gating of all architectural writes.
//             CTRL_MEM_WAIT_EN: FETCH/MEMRD/MEMWR wait on mem_ready.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int         ALU_CTRL_W  = 2,
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   multicycle_control_unit_if.master   bus
);
   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_ex, cond_ex_q, wb_ex, mem_ok;
   logic       is_cmp, cmd_known, flag_we, exec_st;
   logic [1:0] alu_dec, alu_code;
   logic       ir_we_c, pc_we_c, mem_we_c, reg_we_c;
   logic [3:0] cmd;

`ifdef CTRL_MEM_WAIT_EN
   assign mem_ok = bus.mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   assign cmd     = bus.funct[4:1];
   assign is_cmp  = (bus.op == OP_DP) && (cmd == CMD_CMP);
   assign exec_st = (state_q == EXECR) || (state_q == EXECI);

   cond_check u_cond_check (
      .cond    (bus.cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // ALU operation decode from funct[4:1]; unknown commands add without flags
   always_comb begin
      alu_dec   = ALU_ADD;
      cmd_known = 1'b1;
      case (cmd)
         CMD_ADD: alu_dec = ALU_ADD;
         CMD_SUB: alu_dec = ALU_SUB;
         CMD_CMP: alu_dec = ALU_SUB;
         CMD_AND: alu_dec = ALU_AND;
         CMD_ORR: alu_dec = ALU_ORR;
         default: cmd_known = 1'b0;
      endcase
   end

   // Logical ops keep C and V; arithmetic ops take all four flags
   assign flag_we = exec_st && cond_ex && cmd_known && (bus.funct[0] || is_cmp);
   assign flags_d = (alu_dec == ALU_AND || alu_dec == ALU_ORR)
                    ? {bus.alu_flags[3:2], flags_q[1:0]} : bus.alu_flags;

   // ALUWB uses the condition seen in the execute cycle, before that
   // instruction's own flag update lands
   assign wb_ex = (state_q == ALUWB) ? cond_ex_q : cond_ex;

   // State, flag and held-condition registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         flags_q   <= FLAGS_RESET;
         cond_ex_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cond_ex_q <= cond_ex;
         if (flag_we) flags_q <= flags_d;
      end
   end

   // Next-state and per-state control outputs
   always_comb begin
      state_d         = state_q;
      ir_we_c         = 1'b0;
      pc_we_c         = 1'b0;
      mem_we_c        = 1'b0;
      reg_we_c        = 1'b0;
      bus.adr_src     = 1'b0;
      bus.alu_src_a   = SRC_A_REG;
      bus.alu_src_b   = SRC_B_REG;
      bus.result_src  = RES_ALU;
      alu_code        = ALU_ADD;
      case (state_q)
         FETCH: begin
            ir_we_c       = mem_ok;
            pc_we_c       = mem_ok;
            bus.alu_src_a = SRC_A_PC;
            bus.alu_src_b = SRC_B_FOUR;
            if (mem_ok) state_d = DECODE;
         end
         DECODE: begin
            bus.alu_src_a = SRC_A_PC;
            bus.alu_src_b = SRC_B_FOUR;
            case (bus.op)
               OP_MEM:  state_d = MEMADR;
               OP_DP:   state_d = bus.funct[5] ? EXECI : EXECR;
               OP_B:    state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR: begin
            bus.alu_src_b = SRC_B_IMM;
            state_d       = bus.funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.adr_src = 1'b1;
            if (mem_ok) state_d = MEMWB;
         end
         MEMWB: begin
            bus.result_src = RES_MEM;
            reg_we_c       = wb_ex;
            pc_we_c        = wb_ex && (bus.rd == 4'd15);
            state_d        = FETCH;
         end
         MEMWR: begin
            bus.adr_src = 1'b1;
            mem_we_c    = cond_ex && mem_ok;
            if (mem_ok) state_d = FETCH;
         end
         EXECR: begin
            alu_code = alu_dec;
            state_d  = ALUWB;
         end
         EXECI: begin
            bus.alu_src_b = SRC_B_IMM;
            alu_code      = alu_dec;
            state_d       = ALUWB;
         end
         ALUWB: begin
            reg_we_c = wb_ex;
            pc_we_c  = wb_ex && (bus.rd == 4'd15);
            state_d  = FETCH;
         end
         BRANCH: begin
            bus.alu_src_a = SRC_A_PC;
            bus.alu_src_b = SRC_B_IMM;
            pc_we_c       = cond_ex;
            state_d       = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Write enables are forced low while reset is held; CMP never writes rd
   assign bus.ir_we    = ir_we_c  & rst_n;
   assign bus.pc_we    = pc_we_c  & rst_n;
   assign bus.mem_we   = mem_we_c & rst_n;
   assign bus.reg_we   = reg_we_c & ~is_cmp & rst_n;
   assign bus.imm_src  = bus.op;
   assign bus.reg_src  = {(bus.op == OP_MEM) && !bus.funct[0], bus.op == OP_B};
   assign bus.alu_ctrl = ALU_CTRL_W'(alu_code);
   assign bus.flags    = flags_q;
   assign bus.state    = state_q;

endmodule
`default_nettype wire
